// File: rtl/stepper_move_gen.sv
// ---------------------------------------------------------------------------
// stepper_move_gen
//
// Trapezoidal step-pulse generator for a stepper phase sequencer. It accepts
// one move command at a time and waits DIR_SETUP clocks so the direction line
// can settle. It then emits cmd_steps one-cycle step pulses. The step period
// ramps from period_start down towards period_min by accel per step. It
// ramps back up symmetrically so the move ends at period_start.
//
// Parameters
//   DIR_SETUP  clocks between the dir_out update and the first step (>= 1)
//   PER_W      width of period / acceleration quantities (>= 2)
//
// Ports
//   clk_i               system clock, rising edge
//   reset_i             synchronous active-high reset
//   cmd_valid_i         move command presented
//   cmd_ready_o         command accepted this cycle when valid (IDLE only)
//   cmd_steps_i         number of steps to emit
//   cmd_dir_i           1 = forward (+), 0 = reverse (-)
//   cmd_period_start_i  clocks per step at start and end of the move
//   cmd_period_min_i    clocks per step at cruise
//   cmd_accel_i         period change applied after each step
//   abort_i             stop the move immediately (SETUP / RUN only)
//   step_out_o          one-cycle step pulse
//   dir_out_o           latched direction
//   busy_o              high in SETUP and RUN
//   done_o              one-cycle pulse when a move finishes
//   aborted_o           valid with done_o; move ended by abort
//   position_o          signed running step count, wraps modulo 2^32
// ---------------------------------------------------------------------------
module stepper_move_gen #(
   parameter int unsigned DIR_SETUP = 8,
   parameter int unsigned PER_W     = 24
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [15:0]      cmd_steps_i,
   input  logic             cmd_dir_i,
   input  logic [PER_W-1:0] cmd_period_start_i,
   input  logic [PER_W-1:0] cmd_period_min_i,
   input  logic [PER_W-1:0] cmd_accel_i,
   input  logic             abort_i,
   output logic             step_out_o,
   output logic             dir_out_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             aborted_o,
   output logic [31:0]      position_o
);

   // Setup counter holds DIR_SETUP-1 down to 0, one count per SETUP cycle.
   localparam int unsigned SetupVal = (DIR_SETUP > 1) ? (DIR_SETUP - 1) : 0;
   localparam int unsigned SetupW   = (SetupVal > 0) ? $clog2(SetupVal + 1) : 1;

   typedef logic [PER_W:0] ext_t;

   localparam ext_t             ExtTwo   = ext_t'(2);
   localparam logic [PER_W-1:0] PerOne   = PER_W'(1);
   localparam logic [SetupW-1:0] SetupLd = SetupW'(SetupVal);
   localparam logic [SetupW-1:0] SetupOne = SetupW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StRun,
      StDone
   } state_e;

   state_e             state_q, state_d;
   logic               dir_q, dir_d;
   logic               aborted_q, aborted_d;
   logic [31:0]        pos_q, pos_d;
   logic [15:0]        rem_q, rem_d;
   logic [15:0]        ramp_q, ramp_d;
   logic [PER_W-1:0]   period_q, period_d;
   logic [PER_W-1:0]   timer_q, timer_d;
   logic [PER_W-1:0]   per_start_q, per_start_d;
   logic [PER_W-1:0]   per_min_q, per_min_d;
   logic [PER_W-1:0]   accel_q, accel_d;
   logic [SetupW-1:0]  setup_q, setup_d;

   logic               step_fire;

   // -----------------------------------------------------------------------
   // Command clamping, evaluated on the incoming fields at acceptance.
   // Periods below 2 cannot produce distinct pulses, and a cruise period
   // slower than the start period is meaningless, so both are pulled in.
   // -----------------------------------------------------------------------
   ext_t start_x;
   ext_t min_x;

   always_comb begin
      start_x = {1'b0, cmd_period_start_i};
      if (start_x < ExtTwo) begin
         start_x = ExtTwo;
      end
      min_x = {1'b0, cmd_period_min_i};
      if (min_x > start_x) begin
         min_x = start_x;
      end
      if (min_x < ExtTwo) begin
         min_x = ExtTwo;
      end
   end

   // -----------------------------------------------------------------------
   // Period update applied with each step pulse. The ramp counter tracks
   // how many acceleration steps have been taken; once the remaining step
   // count falls to that value the move must start decelerating to land on
   // period_start at the final step. Sums are one bit wider than PER_W so
   // neither the increase nor the saturation test can wrap.
   // -----------------------------------------------------------------------
   logic [15:0]      rem_dec;
   ext_t             inc_x;
   ext_t             floor_x;
   logic [PER_W-1:0] dec_p;
   logic [PER_W-1:0] period_n;
   logic [15:0]      ramp_n;

   always_comb begin
      rem_dec  = rem_q - 16'd1;
      inc_x    = {1'b0, period_q} + {1'b0, accel_q};
      floor_x  = {1'b0, per_min_q} + {1'b0, accel_q};
      dec_p    = period_q - accel_q;
      period_n = period_q;
      ramp_n   = ramp_q;
      if (rem_dec <= ramp_q) begin
         period_n = (inc_x > {1'b0, per_start_q}) ? per_start_q : inc_x[PER_W-1:0];
         if (ramp_q != 16'd0) begin
            ramp_n = ramp_q - 16'd1;
         end
      end else if (period_q > per_min_q) begin
         // period - accel >= min  <=>  period >= min + accel; else saturate.
         period_n = ({1'b0, period_q} >= floor_x) ? dec_p : per_min_q;
         ramp_n   = ramp_q + 16'd1;
      end
   end

   // -----------------------------------------------------------------------
   // FSM next-state and datapath
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      aborted_d   = aborted_q;
      pos_d       = pos_q;
      rem_d       = rem_q;
      ramp_d      = ramp_q;
      period_d    = period_q;
      timer_d     = timer_q;
      per_start_d = per_start_q;
      per_min_d   = per_min_q;
      accel_d     = accel_q;
      setup_d     = setup_q;
      step_fire   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               dir_d       = cmd_dir_i;
               aborted_d   = 1'b0;
               rem_d       = cmd_steps_i;
               ramp_d      = 16'd0;
               per_start_d = start_x[PER_W-1:0];
               per_min_d   = min_x[PER_W-1:0];
               accel_d     = cmd_accel_i;
               setup_d     = SetupLd;
               state_d     = (cmd_steps_i == 16'd0) ? StDone : StSetup;
            end
         end

         StSetup: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = StDone;
            end else if (setup_q == '0) begin
               // Timer counts down to 0 and fires, so period P spans P cycles.
               period_d = per_start_q;
               timer_d  = per_start_q - PerOne;
               state_d  = StRun;
            end else begin
               setup_d = setup_q - SetupOne;
            end
         end

         StRun: begin
            if (abort_i) begin
               aborted_d = 1'b1;
               state_d   = StDone;
            end else if (timer_q == '0) begin
               step_fire = 1'b1;
               pos_d     = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
               rem_d     = rem_dec;
               ramp_d    = ramp_n;
               period_d  = period_n;
               timer_d   = period_n - PerOne;
               if (rem_dec == 16'd0) begin
                  state_d = StDone;
               end
            end else begin
               timer_d = timer_q - PerOne;
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         dir_q       <= 1'b0;
         aborted_q   <= 1'b0;
         pos_q       <= 32'd0;
         rem_q       <= 16'd0;
         ramp_q      <= 16'd0;
         period_q    <= '0;
         timer_q     <= '0;
         per_start_q <= '0;
         per_min_q   <= '0;
         accel_q     <= '0;
         setup_q     <= '0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         aborted_q   <= aborted_d;
         pos_q       <= pos_d;
         rem_q       <= rem_d;
         ramp_q      <= ramp_d;
         period_q    <= period_d;
         timer_q     <= timer_d;
         per_start_q <= per_start_d;
         per_min_q   <= per_min_d;
         accel_q     <= accel_d;
         setup_q     <= setup_d;
      end
   end

   // -----------------------------------------------------------------------
   // Outputs. Decoded outputs are masked by reset so they read as idle in
   // the reset cycle itself, not only after the reset edge.
   // -----------------------------------------------------------------------
   always_comb begin
      step_out_o  = step_fire & ~reset_i;
      cmd_ready_o = (state_q == StIdle) & ~reset_i;
      busy_o      = ((state_q == StSetup) | (state_q == StRun)) & ~reset_i;
      done_o      = (state_q == StDone) & ~reset_i;
      aborted_o   = (state_q == StDone) & aborted_q & ~reset_i;
      dir_out_o   = dir_q;
      position_o  = pos_q;
   end

endmodule

// File: tb/tb_stepper_move_gen.sv
module tb_stepper_move_gen;

   localparam int unsigned DIR_SETUP = 8;
   localparam int unsigned PER_W     = 24;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [15:0]      cmd_steps = 16'd0;
   logic             cmd_dir = 1'b0;
   logic [PER_W-1:0] cmd_period_start = '0;
   logic [PER_W-1:0] cmd_period_min = '0;
   logic [PER_W-1:0] cmd_accel = '0;
   logic             abort = 1'b0;
   logic             step_out;
   logic             dir_out;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [31:0]      position;

   stepper_move_gen #(
      .DIR_SETUP (DIR_SETUP),
      .PER_W     (PER_W)
   ) dut (
      .clk_i              (clk),
      .reset_i            (reset),
      .cmd_valid_i        (cmd_valid),
      .cmd_ready_o        (cmd_ready),
      .cmd_steps_i        (cmd_steps),
      .cmd_dir_i          (cmd_dir),
      .cmd_period_start_i (cmd_period_start),
      .cmd_period_min_i   (cmd_period_min),
      .cmd_accel_i        (cmd_accel),
      .abort_i            (abort),
      .step_out_o         (step_out),
      .dir_out_o          (dir_out),
      .busy_o             (busy),
      .done_o             (done),
      .aborted_o          (aborted),
      .position_o         (position)
   );

   always #5 clk = ~clk;

   // Cycle number: during the cycle after rising edge k, cyc == k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_pass = 0;
   int          exp_q[$];      // expected step_out cycle numbers
   int          mon_e;
   logic [31:0] exp_pos = 32'd0;

   // Scoreboard: each observed step pulse pops the next expected cycle.
   always @(negedge clk) begin
      if (step_out === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL step_unexpected: pulse at cycle %0d, none expected", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc !== mon_e) $display("FAIL step_time: pulse at cycle %0d, required %0d", cyc, mon_e);
            else n_pass++;
         end
      end
   end

   task automatic send_cmd(input int steps, input bit dir, input int ps, input int pm,
                           input int ac, output int t);
      @(negedge clk);
      cmd_steps        = 16'(steps);
      cmd_dir          = dir;
      cmd_period_start = PER_W'(ps);
      cmd_period_min   = PER_W'(pm);
      cmd_accel        = PER_W'(ac);
      cmd_valid        = 1'b1;
      t = -1;
      for (int i = 0; i < 100; i++) begin
         if (cmd_ready === 1'b1) begin
            t = cyc;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [37:0] got;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      got = {cmd_ready, step_out, dir_out, busy, done, aborted, position};
      n_checks++;
      if (got !== 38'd0) $display("FAIL reset_outputs: got %h, required 0", got);
      else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
      exp_pos = 32'd0;
   endtask

   task automatic test_zero_steps();
      int t, at;
      send_cmd(0, 1'b1, 10, 10, 0, t);
      wait_done(10, at);
      n_checks++;
      if (at !== t + 1) $display("FAIL zero_done_time: done at %0d, required %0d", at, t + 1);
      else n_pass++;
      n_checks++;
      if ({aborted, busy} !== 2'b00) $display("FAIL zero_flags: aborted,busy=%b, required 00", {aborted, busy});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || cyc !== t + 2)
         $display("FAIL zero_ready: cmd_ready=%b at %0d, required 1 at %0d", cmd_ready, cyc, t + 2);
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL zero_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
   endtask

   task automatic test_const();
      int t, at;
      send_cmd(4, 1'b1, 10, 10, 0, t);
      exp_q.push_back(t + 18);
      exp_q.push_back(t + 28);
      exp_q.push_back(t + 38);
      exp_q.push_back(t + 48);
      exp_pos = exp_pos + 32'd4;
      wait_done(100, at);
      n_checks++;
      if (at !== t + 49) $display("FAIL const_done_time: done at %0d, required %0d", at, t + 49);
      else n_pass++;
      n_checks++;
      if ({aborted, dir_out} !== 2'b01) $display("FAIL const_flags: aborted,dir=%b, required 01", {aborted, dir_out});
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL const_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL const_missing: %0d pulses not seen, required 0", exp_q.size());
      else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_ramp();
      int t, at;
      send_cmd(6, 1'b0, 10, 4, 3, t);
      // Intervals 10, 7, 4, 4, 7, 10 after DIR_SETUP.
      exp_q.push_back(t + 18);
      exp_q.push_back(t + 25);
      exp_q.push_back(t + 29);
      exp_q.push_back(t + 33);
      exp_q.push_back(t + 40);
      exp_q.push_back(t + 50);
      exp_pos = exp_pos - 32'd6;
      wait_done(100, at);
      n_checks++;
      if (at !== t + 51) $display("FAIL ramp_done_time: done at %0d, required %0d", at, t + 51);
      else n_pass++;
      n_checks++;
      if ({aborted, dir_out} !== 2'b00) $display("FAIL ramp_flags: aborted,dir=%b, required 00", {aborted, dir_out});
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL ramp_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL ramp_missing: %0d pulses not seen, required 0", exp_q.size());
      else n_pass++;
      exp_q.delete();
   endtask

   // Clamp to period 2, min clamp under saturating accel, and underflow saturation.
   task automatic test_period_edges();
      for (int k = 0; k < 3; k++) begin
         int t, at, steps, ps, pm, ac, dn;
         bit dir;
         int off[4];
         case (k)
            0: begin steps = 3; dir = 1'b1; ps = 1; pm = 0; ac = 0;
                     off = '{10, 12, 14, 0}; dn = 15; end
            1: begin steps = 3; dir = 1'b0; ps = 5; pm = 0; ac = 10;
                     off = '{13, 15, 20, 0}; dn = 21; end
            default: begin steps = 4; dir = 1'b1; ps = 10; pm = 3; ac = 20;
                     off = '{18, 21, 24, 34}; dn = 35; end
         endcase
         send_cmd(steps, dir, ps, pm, ac, t);
         for (int i = 0; i < steps; i++) exp_q.push_back(t + off[i]);
         exp_pos = dir ? (exp_pos + 32'(steps)) : (exp_pos - 32'(steps));
         wait_done(100, at);
         n_checks++;
         if (at !== t + dn) $display("FAIL edge%0d_done_time: done at %0d, required %0d", k, at, t + dn);
         else n_pass++;
         n_checks++;
         if (position !== exp_pos)
            $display("FAIL edge%0d_position: got %0d, required %0d", k, $signed(position), $signed(exp_pos));
         else n_pass++;
         n_checks++;
         if (exp_q.size() !== 0) $display("FAIL edge%0d_missing: %0d pulses not seen, required 0", k, exp_q.size());
         else n_pass++;
         exp_q.delete();
      end
   endtask

   task automatic test_abort();
      int t;
      // Abort two cycles after the third pulse of the ramp move.
      send_cmd(6, 1'b0, 10, 4, 3, t);
      exp_q.push_back(t + 18);
      exp_q.push_back(t + 25);
      exp_q.push_back(t + 29);
      exp_pos = exp_pos - 32'd3;
      while (cyc < t + 31) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({done, aborted, busy} !== 3'b110)
         $display("FAIL abort_run_flags: done,aborted,busy=%b at %0d, required 110", {done, aborted, busy}, cyc);
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL abort_run_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
      repeat (25) @(negedge clk);
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL abort_run_missing: %0d pulses not seen, required 0", exp_q.size());
      else n_pass++;
      exp_q.delete();

      // Abort landing on a pulse cycle suppresses that pulse.
      send_cmd(5, 1'b1, 10, 10, 0, t);
      exp_q.push_back(t + 18);
      exp_pos = exp_pos + 32'd1;
      while (cyc < t + 28) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({done, aborted} !== 2'b11) $display("FAIL abort_pulse_flags: done,aborted=%b, required 11", {done, aborted});
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL abort_pulse_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;

      // Abort during SETUP: no pulse at all.
      send_cmd(5, 1'b0, 10, 10, 0, t);
      while (cyc < t + 3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if ({done, aborted, cyc} !== {2'b11, t + 4})
         $display("FAIL abort_setup_flags: done,aborted=%b at %0d, required 11 at %0d", {done, aborted}, cyc, t + 4);
      else n_pass++;
      repeat (20) @(negedge clk);
      n_checks++;
      if (position !== exp_pos) $display("FAIL abort_setup_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int t1, t2, dn, at;
      @(negedge clk);
      cmd_steps = 16'd4; cmd_dir = 1'b1;
      cmd_period_start = PER_W'(10); cmd_period_min = PER_W'(10); cmd_accel = '0;
      cmd_valid = 1'b1;
      t1 = -1;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready === 1'b1) begin t1 = cyc; break; end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      cmd_steps = 16'd2; cmd_dir = 1'b0;
      cmd_period_start = PER_W'(5); cmd_period_min = PER_W'(5);
      exp_q.push_back(t1 + 18);
      exp_q.push_back(t1 + 28);
      exp_q.push_back(t1 + 38);
      exp_q.push_back(t1 + 48);
      exp_pos = exp_pos + 32'd4;
      dn = -1;
      t2 = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1) dn = cyc;
         if (cmd_ready === 1'b1) begin t2 = cyc; break; end
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n_checks++;
      if (dn !== t1 + 49) $display("FAIL b2b_first_done: done at %0d, required %0d", dn, t1 + 49);
      else n_pass++;
      n_checks++;
      if (t2 !== t1 + 50) $display("FAIL b2b_accept: second accept at %0d, required %0d", t2, t1 + 50);
      else n_pass++;
      exp_q.push_back(t2 + 13);
      exp_q.push_back(t2 + 18);
      exp_pos = exp_pos - 32'd2;
      wait_done(100, at);
      n_checks++;
      if (at !== t2 + 19) $display("FAIL b2b_second_done: done at %0d, required %0d", at, t2 + 19);
      else n_pass++;
      n_checks++;
      if (position !== exp_pos) $display("FAIL b2b_position: got %0d, required %0d", $signed(position), $signed(exp_pos));
      else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int t, n_done;
      logic [37:0] got;
      send_cmd(4, 1'b1, 10, 10, 0, t);
      exp_q.push_back(t + 18);
      exp_q.push_back(t + 28);
      while (cyc < t + 33) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      got = {cmd_ready, step_out, dir_out, busy, done, aborted, position};
      n_checks++;
      if (got !== 38'd0) $display("FAIL midreset_outputs: got %h, required 0", got);
      else n_pass++;
      reset = 1'b0;
      exp_pos = 32'd0;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) $display("FAIL midreset_ready: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      n_checks++;
      if (n_done !== 0) $display("FAIL midreset_done: %0d done pulses, required 0", n_done);
      else n_pass++;
      n_checks++;
      if (exp_q.size() !== 0) $display("FAIL midreset_missing: %0d pulses not seen, required 0", exp_q.size());
      else n_pass++;
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_zero_steps();
      test_const();
      test_ramp();
      test_period_edges();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
